pipe_subtractor: RTL
====================

Name: pipe_subtractor

Overview:
- 32-bit pipelined subtractor computing a - b - bin with a parallel-prefix (Kogge-Stone) borrow network.
- Complementary datapath to the team's pipelined prefix adder. It sits beside the adder in the ALU.
- Adds a valid/ready handshake with backpressure, a tag passthrough and result flags, so it can sit behind an issue queue.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; any other value is a compile-time error.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  minuend
- in_b  in  WIDTH  subtrahend
- in_bin  in  1  borrow-in
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- out_diff  out  WIDTH  (a - b - bin) mod 2^32
- out_bout  out  1  borrow-out, unsigned a < b + bin
- out_zero  out  1  out_diff == 0
- out_neg  out  1  out_diff[31]
- out_ovf  out  1  signed overflow
- out_tag  out  TAG_W  in_tag of this operation

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Arithmetic:
  - Computed as a + ~b + (~bin). Per bit, p = a ^ ~b and g = a & ~b. Carry-in to bit 0 is ~bin.
  - Borrow-out: out_bout = ~carry_out[31].
  - Signed overflow: out_ovf = (a[31] != b[31]) && (diff[31] != a[31]).
- Pipeline: 5 register stages, one per prefix level (spans 1, 2, 4, 8, 16). Stage 5 also forms the sum XOR and the flags.
  - Each stage carries valid, tag, the original p bits and a[31]/b[31].
  - With no stall, a result is presented exactly 5 cycles after the handshake.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output completes when out_valid && out_ready.
  - stall = out_valid && !out_ready. During a stall every stage holds: all stage registers, including valid, keep their values.
  - in_ready = !stall && !rst. Combinational from out_ready is permitted.
  - Bubbles are not collapsed. An invalid stage advances like a valid one.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold.
- Throughput: one operation per cycle when out_ready is held at 1.
- Ordering: results leave in acceptance order; tags are returned unchanged.
- Reset:
  - While rst=1, all stage valid bits and out_valid clear at the clock edge.
  - out_diff, out_tag and all flags register to 0.
  - in_ready=0 while rst=1.
  - Operations in flight are discarded and never emitted.
- Simultaneous accept and complete in the same cycle is legal and is the normal streaming case.
- Operand values are not checked. Every 32-bit combination is legal, including a == b and bin=1 with a=0.

Decomposition:
- Shared package alu_pkg:
  - ALU_W=32
  - SUB_LAT=5
  - flag bit indices: ZERO=0, NEG=1, OVF=2, BOUT=3, used by the flag bus in the ALU top
- Sub-module pg_cell: combinational prefix combine. Inputs (g_hi, p_hi, g_lo, p_lo); outputs g = g_hi | (p_hi & g_lo) and p = p_hi & p_lo.
  - Instantiated per bit per level. Pipeline registers stay in pipe_subtractor.

Test Plan:
1. a=5, b=3, bin=0, tag=1, out_ready=1 → 5 cycles later: diff=2, bout=0, zero=0, neg=0, ovf=0, tag=1.
2. a=0, b=1, bin=0 → diff=0xFFFFFFFF, bout=1, neg=1, ovf=0.
3. a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, bout=0, neg=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, ovf=1, bout=1.
4. a=b=0x1234, bin=0 → diff=0, zero=1. Same operands with bin=1 → diff=0xFFFFFFFF, bout=1.
5. Stream 8 back-to-back random operations, tags 0-7; drop out_ready for cycles 7-9. Required response:
   - in_ready=0 during those cycles;
   - outputs held stable;
   - all 8 results emitted in order and matching the reference model;
   - no duplicates.
6. Accept 3 operations, assert rst for 1 cycle while they are in flight → out_valid=0 the next cycle and none of the 3 is ever emitted. A new operation accepted after reset returns correctly in 5 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Constants shared by the ALU datapaths: operand width, subtractor latency and
// bit positions of the result flag bus.
package alu_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned SUB_LAT = 5;

    localparam int unsigned ZERO = 0;
    localparam int unsigned NEG  = 1;
    localparam int unsigned OVF  = 2;
    localparam int unsigned BOUT = 3;

endpackage

// File: rtl/pg_cell.sv
// Kogge-Stone prefix combine of a higher (g_hi, p_hi) group with the adjacent
// lower (g_lo, p_lo) group.
module pg_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/pipe_subtractor.sv
// Five-stage pipelined a - b - bin using a Kogge-Stone carry network over a + ~b + ~bin,
// with valid/ready backpressure, tag passthrough and result flags.
module pipe_subtractor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned NMID = SUB_LAT - 1;

    if (WIDTH != ALU_W) begin : g_width_check
        $error("pipe_subtractor supports only WIDTH=32");
    end

    logic             stall;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] carries;
    logic [WIDTH-1:0] diff;

    // Level k reads g_src/p_src[k] and produces g_cmb/p_cmb[k] with span 2^k.
    logic [WIDTH-1:0] g_src [SUB_LAT];
    logic [WIDTH-1:0] p_src [SUB_LAT];
    logic [WIDTH-1:0] g_cmb [SUB_LAT];
    logic [WIDTH-1:0] p_cmb [SUB_LAT];

    logic             vld_q   [NMID];
    logic [TAG_W-1:0] tag_q   [NMID];
    logic [WIDTH-1:0] po_q    [NMID];
    logic [WIDTH-1:0] g_q     [NMID];
    logic [WIDTH-1:0] p_q     [NMID];
    logic             cin_q   [NMID];
    logic             a_msb_q [NMID];
    logic             b_msb_q [NMID];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !rst;

    // Carry-in (~bin) is folded into bit 0's generate so the prefix yields true carries.
    always_comb begin
        p_in     = in_a ^ ~in_b;
        g_src[0] = (in_a & ~in_b) | {{(WIDTH-1){1'b0}}, p_in[0] & ~in_bin};
        p_src[0] = p_in;
        for (int k = 1; k < SUB_LAT; k++) begin
            g_src[k] = g_q[k-1];
            p_src[k] = p_q[k-1];
        end
    end

    for (genvar k = 0; k < SUB_LAT; k++) begin : g_level
        logic [WIDTH-1:0] g_lvl;
        logic [WIDTH-1:0] p_lvl;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_cell
                pg_cell u_pg (
                    .g_hi (g_src[k][i]),
                    .p_hi (p_src[k][i]),
                    .g_lo (g_src[k][i - (1 << k)]),
                    .p_lo (p_src[k][i - (1 << k)]),
                    .g    (g_lvl[i]),
                    .p    (p_lvl[i])
                );
            end else begin : g_pass
                assign g_lvl[i] = g_src[k][i];
                assign p_lvl[i] = p_src[k][i];
            end
        end
        assign g_cmb[k] = g_lvl;
        assign p_cmb[k] = p_lvl;
    end

    always_comb begin
        carries = {g_cmb[SUB_LAT-1][WIDTH-2:0], cin_q[NMID-1]};
        diff    = po_q[NMID-1] ^ carries;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NMID; k++) begin
                vld_q[k]   <= 1'b0;
                tag_q[k]   <= '0;
                po_q[k]    <= '0;
                g_q[k]     <= '0;
                p_q[k]     <= '0;
                cin_q[k]   <= 1'b0;
                a_msb_q[k] <= 1'b0;
                b_msb_q[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_bout  <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            vld_q[0]   <= in_valid;
            tag_q[0]   <= in_tag;
            po_q[0]    <= p_in;
            g_q[0]     <= g_cmb[0];
            p_q[0]     <= p_cmb[0];
            cin_q[0]   <= ~in_bin;
            a_msb_q[0] <= in_a[WIDTH-1];
            b_msb_q[0] <= in_b[WIDTH-1];
            for (int k = 1; k < NMID; k++) begin
                vld_q[k]   <= vld_q[k-1];
                tag_q[k]   <= tag_q[k-1];
                po_q[k]    <= po_q[k-1];
                g_q[k]     <= g_cmb[k];
                p_q[k]     <= p_cmb[k];
                cin_q[k]   <= cin_q[k-1];
                a_msb_q[k] <= a_msb_q[k-1];
                b_msb_q[k] <= b_msb_q[k-1];
            end
            out_valid <= vld_q[NMID-1];
            out_tag   <= tag_q[NMID-1];
            out_diff  <= diff;
            out_bout  <= ~g_cmb[SUB_LAT-1][WIDTH-1];
            out_zero  <= (diff == '0);
            out_neg   <= diff[WIDTH-1];
            out_ovf   <= (a_msb_q[NMID-1] != b_msb_q[NMID-1]) &&
                         (diff[WIDTH-1] != a_msb_q[NMID-1]);
        end
    end

endmodule
